access_session_ctrl: RTL and testbench
======================================

Name: access_session_ctrl

Overview:
- Sequential session controller for the profile/functionality access-control logic.
- Logs a profile in from switches CH7..CH5, then accepts function requests encoded on B3, B2 and CH4.
- Checks each request against the latched profile's permission mask and drives grant/deny LEDs plus the LED-matrix permission map.
- Adds login-failure lockout and an inactivity timeout.

Parameters:
- HOLD_CYC, 50_000_000, cycles the grant/deny indication is held (1 s at 50 MHz).
- TIMEOUT_CYC, 500_000_000, idle cycles in SESSION before automatic logout.
- LOCK_CYC, 250_000_000, lockout duration after MAX_FAIL failed logins.
- MAX_FAIL, 3, consecutive failed logins that trigger lockout.
- CNT_W, 32, width of the shared cycle counter; must hold max(HOLD_CYC, TIMEOUT_CYC, LOCK_CYC).

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous reset, active-high.
- CH7, CH6, CH5  in  1 each  profile code {CH7,CH6,CH5}, asynchronous.
- CH4  in  1  function-code LSB.
- B3, B2  in  1 each  function-code MSBs; function F = {B3,B2,CH4}.
- B0  in  1  confirm button (login / execute), pressed = 1, asynchronous.
- B1  in  1  logout button, pressed = 1, asynchronous.
- LED0  out  1  session active.
- LED2  out  1  grant indication.
- LED3  out  1  deny indication (request or login).
- LED5  out  1  locked out.
- M1_C0  out  1  latched profile is privileged (ADM or TESTER) and session is active.
- M1_L6..M1_L0  out  1 each  M1_Lk = function k+1 permitted for the latched profile; all 0 outside a session.
- FUNC_GO  out  1  one-cycle pulse when a request is granted.
- FUNC_ID  out  3  F of the last granted request; held until the next grant.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high (RST).
- Inputs: CH7..CH4, B3, B2, B0 and B1 pass through 2-FF synchronizers. B0 and B1 get rising-edge detection. A press first sampled high at edge N yields an internal edge pulse at N+2; the resulting state change and FUNC_GO are registered at N+3.
- Profile codes:
  - ADM = 101, mask 1111111.
  - TESTER = 011, mask 0101111 (functions 1–4 and 6).
  - USER = 001, mask 0000000.
  - GUEST = 110, mask 0000000.
  - Any other code is invalid.
- States: IDLE, SESSION, GRANT, DENY, LOGIN_FAIL, LOCKED.
- IDLE:
  - B0 edge with a valid code: latch the profile, clear the fail counter, go to SESSION.
  - B0 edge with an invalid code: increment the fail counter. If the count reaches MAX_FAIL, go to LOCKED; otherwise go to LOGIN_FAIL.
- SESSION:
  - B1 edge: go to IDLE.
  - Otherwise, B0 edge with F = 0: ignored, but restarts the timeout.
  - Otherwise, B0 edge with mask[F-1] = 1: go to GRANT, pulse FUNC_GO, load FUNC_ID = F.
  - Otherwise, B0 edge with mask[F-1] = 0: go to DENY.
  - Counter reaching TIMEOUT_CYC-1 with no edges: go to IDLE.
- GRANT / DENY:
  - Hold HOLD_CYC cycles, then return to SESSION with the timeout restarted.
  - B0 edges are ignored.
  - B1 edge goes to IDLE immediately.
- LOGIN_FAIL: LED3 held for HOLD_CYC cycles, then IDLE.
- LOCKED:
  - LED5 = 1 for LOCK_CYC cycles; all buttons are ignored.
  - Then IDLE with the fail counter cleared.
- Counter: one shared counter, cleared on every state entry.
- Simultaneous B0 and B1 edges: B1 wins.
- Profile switches are ignored after login; the latched profile stays fixed until the next IDLE.
- Output decode:
  - LED0 = 1 in SESSION, GRANT and DENY.
  - LED2 = 1 only in GRANT.
  - LED3 = 1 in DENY and LOGIN_FAIL.
  - M1 outputs come from the latched mask gated by LED0.
- All outputs are registered.
- Reset, including mid-operation: state IDLE, counter 0, fail counter 0, latched profile 000, FUNC_ID 000, every output 0.

Decomposition:
- Package access_pkg holds:
  - profile code constants (ADM, TESTER, USER, GUEST);
  - the state enum;
  - function perm_mask(profile) returning 7 bits.
- One sub-module, btn_sync_edge: 2-FF synchronizer plus rising-edge pulse, instantiated for B0 and B1.
- Level inputs use plain synchronizers.

Test Plan (HOLD_CYC=4, TIMEOUT_CYC=20, LOCK_CYC=10, MAX_FAIL=3):
- Login and grant: code 101, B0 pulse; then F=7 ({B3,B2,CH4}=111), B0 pulse → LED0=1, M1_L6..L0=1111111, M1_C0=1. FUNC_GO is high for exactly 1 cycle, 3 cycles after B0 is sampled. FUNC_ID=7. LED2=1 for 4 cycles, then SESSION.
- TESTER denied: code 011, login, request F=5 → LED3=1 for 4 cycles, FUNC_GO never asserted, M1_L6..L0=0101111.
- Lockout: three logins with code 000 → LED3 holds after the first two; after the third, LED5=1 for 10 cycles with B0 ignored, then IDLE. A fourth login with 101 then succeeds.
- Timeout: USER login (M1_C0=0, all M1_L=0) with no presses for 20 cycles → LED0 returns to 0.
- Simultaneous events: B0 and B1 pressed in the same cycle in SESSION → IDLE, no FUNC_GO. B1 during GRANT hold → IDLE immediately.
- Reset mid-operation: RST asserted during LOCKED and during GRANT → next cycle all outputs 0 and state IDLE. A fresh valid login works and the fail counter starts from 0.

Source files
------------

// File: rtl/access_pkg.sv
// Shared definitions for the access session controller: profile codes,
// controller states and the per-profile permission table.
package access_pkg;

    localparam logic [2:0] PROF_ADM    = 3'b101;
    localparam logic [2:0] PROF_TESTER = 3'b011;
    localparam logic [2:0] PROF_USER   = 3'b001;
    localparam logic [2:0] PROF_GUEST  = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SESSION,
        ST_GRANT,
        ST_DENY,
        ST_LOGIN_FAIL,
        ST_LOCKED
    } state_t;

    // Bit k of the result permits function k+1.
    function automatic logic [6:0] perm_mask(input logic [2:0] profile);
        case (profile)
            PROF_ADM:    return 7'b1111111;
            PROF_TESTER: return 7'b0101111;
            default:     return 7'b0000000;
        endcase
    endfunction

    function automatic logic profile_valid(input logic [2:0] profile);
        return (profile == PROF_ADM) || (profile == PROF_TESTER) ||
               (profile == PROF_USER) || (profile == PROF_GUEST);
    endfunction

endpackage

// File: rtl/access_session_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// registered rising-edge detector producing a one-cycle pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronize the button, remember its previous level and register the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/access_session_ctrl.sv
// Session controller: profile login with lockout, permission-checked function
// requests, timed grant/deny indication and inactivity logout.
module access_session_ctrl
    import access_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned LOCK_CYC    = 250_000_000,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CH7,
    input  logic       CH6,
    input  logic       CH5,
    input  logic       CH4,
    input  logic       B3,
    input  logic       B2,
    input  logic       B0,
    input  logic       B1,
    output logic       LED0,
    output logic       LED2,
    output logic       LED3,
    output logic       LED5,
    output logic       M1_C0,
    output logic       M1_L6,
    output logic       M1_L5,
    output logic       M1_L4,
    output logic       M1_L3,
    output logic       M1_L2,
    output logic       M1_L1,
    output logic       M1_L0,
    output logic       FUNC_GO,
    output logic [2:0] FUNC_ID
);

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic [5:0]        lvl_meta;
    logic [5:0]        lvl_sync;
    logic [2:0]        code;
    logic [2:0]        func;
    logic              b0_edge;
    logic              b1_edge;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [FAIL_W-1:0] fails;
    logic [FAIL_W-1:0] fails_nx;
    logic [2:0]        profile;
    logic [2:0]        profile_nx;
    logic              go_nx;
    logic              active_nx;
    logic [7:0]        mask_ext;

    btn_sync_edge u_b0 (.clk(CLK), .rst(RST), .btn(B0), .pulse(b0_edge));
    btn_sync_edge u_b1 (.clk(CLK), .rst(RST), .btn(B1), .pulse(b1_edge));

    // Two-flop synchronizers for the profile and function-code switches.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lvl_meta <= '0;
            lvl_sync <= '0;
        end else begin
            lvl_meta <= {CH7, CH6, CH5, B3, B2, CH4};
            lvl_sync <= lvl_meta;
        end
    end

    assign code     = lvl_sync[5:3];
    assign func     = lvl_sync[2:0];
    // Index 0 is a dummy so the function code can index the mask directly.
    assign mask_ext = {perm_mask(profile), 1'b0};

    // Next-state decisions; B1 is checked first so it beats a simultaneous B0.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CNT_W'(1);
        fails_nx   = fails;
        profile_nx = profile;
        go_nx      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (b0_edge) begin
                    if (profile_valid(code)) begin
                        profile_nx = code;
                        fails_nx   = '0;
                        state_nx   = ST_SESSION;
                    end else begin
                        fails_nx = fails + FAIL_W'(1);
                        if (fails == FAIL_W'(MAX_FAIL - 1)) begin
                            state_nx = ST_LOCKED;
                        end else begin
                            state_nx = ST_LOGIN_FAIL;
                        end
                    end
                end
            end
            ST_SESSION: begin
                if (b1_edge) begin
                    state_nx = ST_IDLE;
                end else if (b0_edge && func == 3'd0) begin
                    cnt_nx = '0;
                end else if (b0_edge && mask_ext[func]) begin
                    state_nx = ST_GRANT;
                    go_nx    = 1'b1;
                end else if (b0_edge) begin
                    state_nx = ST_DENY;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_GRANT, ST_DENY: begin
                if (b1_edge) begin
                    state_nx = ST_IDLE;
                end else if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    state_nx = ST_SESSION;
                end
            end
            ST_LOGIN_FAIL: begin
                if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (cnt == CNT_W'(LOCK_CYC - 1)) begin
                    state_nx = ST_IDLE;
                    fails_nx = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (state_nx != state || state_nx == ST_IDLE) begin
            cnt_nx = '0;
        end
    end

    assign active_nx = (state_nx == ST_SESSION) || (state_nx == ST_GRANT) ||
                       (state_nx == ST_DENY);

    // Controller state plus every output, registered from the next-state values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            fails   <= '0;
            profile <= '0;
            LED0    <= 1'b0;
            LED2    <= 1'b0;
            LED3    <= 1'b0;
            LED5    <= 1'b0;
            M1_C0   <= 1'b0;
            {M1_L6, M1_L5, M1_L4, M1_L3, M1_L2, M1_L1, M1_L0} <= '0;
            FUNC_GO <= 1'b0;
            FUNC_ID <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            fails   <= fails_nx;
            profile <= profile_nx;
            LED0    <= active_nx;
            LED2    <= (state_nx == ST_GRANT);
            LED3    <= (state_nx == ST_DENY) || (state_nx == ST_LOGIN_FAIL);
            LED5    <= (state_nx == ST_LOCKED);
            M1_C0   <= active_nx &&
                       (profile_nx == PROF_ADM || profile_nx == PROF_TESTER);
            {M1_L6, M1_L5, M1_L4, M1_L3, M1_L2, M1_L1, M1_L0} <=
                perm_mask(profile_nx) & {7{active_nx}};
            FUNC_GO <= go_nx;
            if (go_nx) begin
                FUNC_ID <= func;
            end
        end
    end

endmodule

// File: tb/tb_access_session_ctrl.sv
// Testbench for access_session_ctrl: table-driven login/request vectors,
// hand-written corner sequences and randomized traffic, all cross-checked
// every cycle against a timer-based behavioural model.
module tb_access_session_ctrl;

    localparam int HOLD    = 4;
    localparam int TIMEOUT = 20;
    localparam int LOCK    = 10;
    localparam int MAXF    = 3;

    localparam int M_IDLE = 0, M_SESS = 1, M_GRANT = 2, M_DENY = 3, M_FAIL = 4, M_LOCK = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CH7 = 0, CH6 = 0, CH5 = 0, CH4 = 0, B3 = 0, B2 = 0, B0 = 0, B1 = 0;
    logic LED0, LED2, LED3, LED5, M1_C0;
    logic M1_L6, M1_L5, M1_L4, M1_L3, M1_L2, M1_L1, M1_L0;
    logic FUNC_GO;
    logic [2:0] FUNC_ID;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    wire [6:0]  m1   = {M1_L6, M1_L5, M1_L4, M1_L3, M1_L2, M1_L1, M1_L0};
    wire [14:0] outs = {LED0, LED2, LED3, LED5, M1_C0, m1, FUNC_GO, FUNC_ID};

    access_session_ctrl #(
        .HOLD_CYC(HOLD), .TIMEOUT_CYC(TIMEOUT), .LOCK_CYC(LOCK),
        .MAX_FAIL(MAXF), .CNT_W(32)
    ) dut (
        .CLK(CLK), .RST(RST), .CH7(CH7), .CH6(CH6), .CH5(CH5), .CH4(CH4),
        .B3(B3), .B2(B2), .B0(B0), .B1(B1),
        .LED0(LED0), .LED2(LED2), .LED3(LED3), .LED5(LED5), .M1_C0(M1_C0),
        .M1_L6(M1_L6), .M1_L5(M1_L5), .M1_L4(M1_L4), .M1_L3(M1_L3),
        .M1_L2(M1_L2), .M1_L1(M1_L1), .M1_L0(M1_L0),
        .FUNC_GO(FUNC_GO), .FUNC_ID(FUNC_ID)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int         m_mode = M_IDLE;
    int         m_left = 0;
    int         m_fails = 0;
    logic [2:0] m_prof = 3'd0;
    logic [2:0] m_fid = 3'd0;
    logic       m_go = 1'b0;
    logic [4:0] h_b0 = '0;
    logic [4:0] h_b1 = '0;
    logic [2:0] h_code [5];
    logic [2:0] h_f [5];

    function automatic logic allowed(input logic [2:0] p, input int f);
        if (p == 3'b101) return (f >= 1 && f <= 7);
        if (p == 3'b011) return (f == 1 || f == 2 || f == 3 || f == 4 || f == 6);
        return 1'b0;
    endfunction

    function automatic logic valid_code(input logic [2:0] p);
        return p == 3'b101 || p == 3'b011 || p == 3'b001 || p == 3'b110;
    endfunction

    function automatic void enter(input int m);
        m_mode = m;
        case (m)
            M_SESS:                  m_left = TIMEOUT;
            M_GRANT, M_DENY, M_FAIL: m_left = HOLD;
            M_LOCK:                  m_left = LOCK;
            default:                 m_left = 0;
        endcase
    endfunction

    function automatic logic [14:0] model_outs();
        logic       act;
        logic [6:0] mm;
        act = (m_mode == M_SESS || m_mode == M_GRANT || m_mode == M_DENY);
        for (int k = 1; k <= 7; k++) mm[k-1] = act & allowed(m_prof, k);
        return {act, m_mode == M_GRANT, (m_mode == M_DENY || m_mode == M_FAIL),
                m_mode == M_LOCK, act && (m_prof == 3'b101 || m_prof == 3'b011),
                mm, m_go, m_fid};
    endfunction

    // Press events reach the controller three edges after first being sampled;
    // switch levels are seen two edges after sampling.
    always @(posedge CLK) begin : model_step
        logic       e0, e1;
        logic [2:0] code, f;
        if (RST) begin
            h_b0 = '0; h_b1 = '0;
            for (int i = 0; i < 5; i++) begin h_code[i] = 3'd0; h_f[i] = 3'd0; end
            m_mode = M_IDLE; m_left = 0; m_fails = 0; m_prof = 3'd0; m_fid = 3'd0; m_go = 1'b0;
        end else begin
            h_b0 = {h_b0[3:0], B0};
            h_b1 = {h_b1[3:0], B1};
            for (int i = 4; i > 0; i--) begin h_code[i] = h_code[i-1]; h_f[i] = h_f[i-1]; end
            h_code[0] = {CH7, CH6, CH5};
            h_f[0]    = {B3, B2, CH4};
            e0 = h_b0[3] & ~h_b0[4];
            e1 = h_b1[3] & ~h_b1[4];
            code = h_code[2];
            f    = h_f[2];
            m_go = 1'b0;
            case (m_mode)
                M_IDLE: if (e0) begin
                    if (valid_code(code)) begin
                        m_prof = code; m_fails = 0; enter(M_SESS);
                    end else begin
                        m_fails++;
                        if (m_fails >= MAXF) enter(M_LOCK); else enter(M_FAIL);
                    end
                end
                M_SESS: begin
                    if (e1) enter(M_IDLE);
                    else if (e0 && f == 0) m_left = TIMEOUT;
                    else if (e0 && allowed(m_prof, int'(f))) begin
                        enter(M_GRANT); m_go = 1'b1; m_fid = f;
                    end
                    else if (e0) enter(M_DENY);
                    else if (m_left == 1) enter(M_IDLE);
                    else m_left--;
                end
                M_GRANT, M_DENY: begin
                    if (e1) enter(M_IDLE);
                    else if (m_left == 1) enter(M_SESS);
                    else m_left--;
                end
                M_FAIL: if (m_left == 1) enter(M_IDLE); else m_left--;
                M_LOCK: if (m_left == 1) begin enter(M_IDLE); m_fails = 0; end else m_left--;
                default: enter(M_IDLE);
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] code, input logic [2:0] f,
                                 input logic b0, input logic b1);
        {CH7, CH6, CH5} = code;
        {B3, B2, CH4}   = f;
        B0 = b0;
        B1 = b1;
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Holds the buttons for one cycle, then releases them.
    task automatic press(input logic [2:0] code, input logic [2:0] f,
                         input logic b0, input logic b1);
        applyStimulus(code, f, b0, b1);
        waitCyc(1);
        applyStimulus(code, f, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        RST = 1'b1;
        applyStimulus(3'd0, 3'd0, 1'b0, 1'b0);
        waitCyc(2);
        RST = 1'b0;
    endtask

    // Continuous comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) checkOutput("model", {1'b0, outs}, {1'b0, model_outs()});
    end

    typedef struct {
        logic [2:0] code;
        logic [2:0] f;
        logic [6:0] m1;
        logic       c0;
        logic       grant;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{3'b101, 3'd7, 7'b1111111, 1'b1, 1'b1};
        vecs[1] = '{3'b011, 3'd5, 7'b0101111, 1'b1, 1'b0};
        vecs[2] = '{3'b011, 3'd6, 7'b0101111, 1'b1, 1'b1};
        vecs[3] = '{3'b011, 3'd4, 7'b0101111, 1'b1, 1'b1};
        vecs[4] = '{3'b001, 3'd1, 7'b0000000, 1'b0, 1'b0};
        vecs[5] = '{3'b110, 3'd3, 7'b0000000, 1'b0, 1'b0};
        vecs[6] = '{3'b101, 3'd1, 7'b1111111, 1'b1, 1'b1};

        doReset();
        checkOutput("reset_outs", {1'b0, outs}, 16'd0);
        chk_en = 1'b1;

        // Table-driven login + single request.
        for (int i = 0; i < 7; i++) begin
            doReset();
            press(vecs[i].code, 3'd0, 1'b1, 1'b0);
            waitCyc(3);
            checkOutput("login_led0", LED0, 1);
            checkOutput("login_m1", m1, vecs[i].m1);
            checkOutput("login_c0", M1_C0, vecs[i].c0);
            press(vecs[i].code, vecs[i].f, 1'b1, 1'b0);
            waitCyc(2);
            checkOutput("go_early", FUNC_GO, 0);
            waitCyc(1);
            checkOutput("go", FUNC_GO, vecs[i].grant);
            checkOutput("led2", LED2, vecs[i].grant);
            checkOutput("led3", LED3, !vecs[i].grant);
            checkOutput("func_id", FUNC_ID, vecs[i].grant ? vecs[i].f : 3'd0);
            waitCyc(1);
            checkOutput("go_after", FUNC_GO, 0);
            waitCyc(2);
            checkOutput("hold_led", {LED2, LED3}, {vecs[i].grant, !vecs[i].grant});
            waitCyc(1);
            checkOutput("hold_end", {LED0, LED2, LED3}, 3'b100);
        end

        // Lockout after three invalid logins.
        doReset();
        for (int k = 0; k < 2; k++) begin
            press(3'b000, 3'd0, 1'b1, 1'b0);
            waitCyc(3);
            checkOutput("fail_led3", {LED3, LED5}, 2'b10);
            waitCyc(4);
            checkOutput("fail_end", LED3, 0);
        end
        press(3'b000, 3'd0, 1'b1, 1'b0);
        waitCyc(3);
        checkOutput("lock_enter", {LED3, LED5}, 2'b01);
        press(3'b101, 3'd0, 1'b1, 1'b0);
        waitCyc(8);
        checkOutput("lock_hold", {LED0, LED5}, 2'b01);
        waitCyc(1);
        checkOutput("lock_end", {LED0, LED5}, 2'b00);
        press(3'b101, 3'd0, 1'b1, 1'b0);
        waitCyc(3);
        checkOutput("relogin", {LED0, m1}, {1'b1, 7'h7F});

        // Inactivity timeout for a USER session.
        doReset();
        press(3'b001, 3'd0, 1'b1, 1'b0);
        waitCyc(3);
        checkOutput("user_login", {LED0, M1_C0, m1}, {1'b1, 1'b0, 7'h00});
        waitCyc(19);
        checkOutput("timeout_pre", LED0, 1);
        waitCyc(1);
        checkOutput("timeout", LED0, 0);

        // Simultaneous B0 and B1 in SESSION.
        doReset();
        press(3'b101, 3'd0, 1'b1, 1'b0);
        waitCyc(3);
        press(3'b101, 3'd7, 1'b1, 1'b1);
        waitCyc(2);
        checkOutput("simul_pre", LED0, 1);
        waitCyc(1);
        checkOutput("simul", {LED0, LED2, FUNC_GO}, 3'b000);

        // B1 during the GRANT hold.
        press(3'b101, 3'd0, 1'b1, 1'b0);
        waitCyc(3);
        press(3'b101, 3'd7, 1'b1, 1'b0);
        press(3'b101, 3'd7, 1'b0, 1'b1);
        waitCyc(2);
        checkOutput("b1_grant", {LED2, FUNC_GO, FUNC_ID}, {2'b11, 3'd7});
        waitCyc(1);
        checkOutput("b1_idle", {LED0, LED2}, 2'b00);

        // Reset during GRANT.
        doReset();
        press(3'b101, 3'd0, 1'b1, 1'b0);
        waitCyc(3);
        press(3'b101, 3'd7, 1'b1, 1'b0);
        waitCyc(3);
        checkOutput("pre_rst_grant", LED2, 1);
        RST = 1'b1;
        waitCyc(1);
        checkOutput("rst_grant_outs", {1'b0, outs}, 16'd0);
        RST = 1'b0;

        // Reset during LOCKED, then the fail count restarts from zero.
        for (int k = 0; k < 3; k++) begin
            press(3'b000, 3'd0, 1'b1, 1'b0);
            waitCyc(7);
        end
        checkOutput("pre_rst_lock", LED5, 1);
        RST = 1'b1;
        waitCyc(1);
        checkOutput("rst_lock_outs", {1'b0, outs}, 16'd0);
        RST = 1'b0;
        press(3'b000, 3'd0, 1'b1, 1'b0);
        waitCyc(3);
        checkOutput("fail_after_rst", {LED3, LED5}, 2'b10);
        waitCyc(4);
        press(3'b101, 3'd0, 1'b1, 1'b0);
        waitCyc(3);
        checkOutput("login_after_rst", LED0, 1);

        // Randomized traffic checked by the model.
        for (int n = 0; n < 1500; n++) begin
            RST = ($urandom_range(0, 249) == 0);
            applyStimulus(3'($urandom), 3'($urandom),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0));
            waitCyc(1);
        end
        RST = 1'b0;
        applyStimulus(3'd0, 3'd0, 1'b0, 1'b0);
        waitCyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
